// File: rtl/div_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl_if
//
// Request/response bundle between the EX stage and the sequential divider.
//
// Signals (direction as seen by the divider, i.e. the slave modport):
//   div_valid     in   1     EX holds a divide op; opcode/operands stable while high
//   div_opcode    in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand1      in   XLEN  dividend (rs1)
//   operand2      in   XLEN  divisor (rs2)
//   flush         in   1     pipeline flush; abort any op in flight
//   div_ready     out  1     divider idle and able to accept
//   stall_o       out  1     freeze IF/ID/EX while the loop is busy
//   result_valid  out  1     one-cycle result strobe
//   result_o      out  XLEN  quotient or remainder
//
// master: the EX-stage side that issues requests.
// slave:  the divider.
// -----------------------------------------------------------------------------
interface div_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            div_valid;
    logic [1:0]      div_opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            div_ready;
    logic            stall_o;
    logic            result_valid;
    logic [XLEN-1:0] result_o;

    modport master (
        output div_valid,
        output div_opcode,
        output operand1,
        output operand2,
        output flush,
        input  div_ready,
        input  stall_o,
        input  result_valid,
        input  result_o
    );

    modport slave (
        input  div_valid,
        input  div_opcode,
        input  operand1,
        input  operand2,
        input  flush,
        output div_ready,
        output stall_o,
        output result_valid,
        output result_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage.
//   - One request per valid/ready handshake.
//   - Divide-by-zero and signed overflow resolve in a single cycle.
//   - Everything else runs a radix-2 restoring shift-subtract loop on
//     magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
//   - stall_o freezes IF/ID/EX while the loop is busy.
//
// Ports:
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous reset, active low
//   bus    slave modport of div_seq_ctrl_if (request, flush, ready, stall,
//          result strobe and result value)
//
// Latency from the accept edge to result_valid:
//   special cases 1 cycle, normal ops XLEN+2 cycles.
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst_n,
    div_seq_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;

    // -------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    logic            accept;
    logic            op_signed;
    logic            op_rem;
    logic            sign1;
    logic            sign2;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;

    assign accept    = (state_q == IDLE) & bus.div_valid & ~bus.flush;
    assign op_signed = ~bus.div_opcode[0];
    assign op_rem    = bus.div_opcode[1];

    // Signs are forced to zero for the unsigned forms so the magnitude path
    // and the sign-fix stage need no separate unsigned handling.
    assign sign1 = op_signed & bus.operand1[XLEN-1];
    assign sign2 = op_signed & bus.operand2[XLEN-1];

    // |MIN_NEG| is MIN_NEG again, which is the correct unsigned magnitude.
    assign abs1 = sign1 ? (-bus.operand1) : bus.operand1;
    assign abs2 = sign2 ? (-bus.operand2) : bus.operand2;

    assign div_zero = (bus.operand2 == '0);
    assign overflow = op_signed & (bus.operand1 == MIN_NEG) & (bus.operand2 == ALL_ONE);

    // -------------------------------------------------------------------------
    // One restoring-division step
    // -------------------------------------------------------------------------
    // The shifted partial remainder needs XLEN+1 bits; the MSB of the
    // difference is the borrow, so it doubles as the compare result.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic            rem_ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};
    assign rem_ge    = ~rem_diff[XLEN];
    // After a successful subtract the remainder is below dvsr, so it fits.
    assign rem_step  = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], rem_ge};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        res_d    = res_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d = op_rem;
                    if (div_zero) begin
                        res_d   = op_rem ? bus.operand1 : ALL_ONE;
                        state_d = DONE;
                    end else if (overflow) begin
                        res_d   = op_rem ? '0 : MIN_NEG;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs1;
                        dvsr_d  = abs2;
                        q_neg_d = sign1 ^ sign2;
                        r_neg_d = sign1;
                        cnt_d   = CW'(XLEN);
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_rem_q) begin
                    res_d = r_neg_q ? (-rem_q) : rem_q;
                end else begin
                    res_d = q_neg_q ? (-quo_q) : quo_q;
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush only redirects control; datapath registers keep whatever
        // they were given above, which is harmless once back in IDLE.
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            res_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            res_q    <= res_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // div_ready depends on state only, so there is no combinational path
    // from div_valid back to div_ready.
    assign bus.div_ready    = (state_q == IDLE);
    assign bus.result_valid = (state_q == DONE) & ~bus.flush;
    assign bus.result_o     = res_q;

    // Stall covers the accept cycle through the FIX cycle; DONE releases the
    // pipeline in the same cycle the result is presented.
    always_comb begin
        bus.stall_o = 1'b0;
        case (state_q)
            IDLE:       bus.stall_o = accept;
            CALC, FIX:  bus.stall_o = bus.div_valid;
            default:    bus.stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int          MAX_WAIT = 40;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    div_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    div_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the RV32M rules.
    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.div_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.div_opcode = 2'b00;
        bus.operand1   = '0;
        bus.operand2   = '0;
    endtask

    // Issues one op, holds valid until the result strobe, checks handshake,
    // latency, stall window, result and single-cycle pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int          n;
        bit          seen;
        bit          stall_ok;
        logic [31:0] exp_res;
        int          exp_lat;
        exp_res = ref_res(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : XLEN + 2;
        @(negedge clk);
        bus.div_valid  = 1'b1;
        bus.div_opcode = op;
        bus.operand1   = a;
        bus.operand2   = b;
        #1;
        check({tag, ".ready_acc"}, 32'(bus.div_ready), 32'd1);
        check({tag, ".stall_acc"}, 32'(bus.stall_o), 32'd1);
        n        = 0;
        seen     = 0;
        stall_ok = 1;
        while (!seen && n < MAX_WAIT) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.result_valid) seen = 1;
            else if (!bus.stall_o) stall_ok = 0;
        end
        check({tag, ".latency"}, 32'(seen ? n : 0), 32'(exp_lat));
        check({tag, ".stall_win"}, 32'(stall_ok), 32'd1);
        if (seen) begin
            check({tag, ".result"}, bus.result_o, exp_res);
            check({tag, ".stall_done"}, 32'(bus.stall_o), 32'd0);
            check({tag, ".ready_done"}, 32'(bus.div_ready), 32'd0);
        end
        bus.div_valid = 1'b0;
        @(negedge clk);
        check({tag, ".pulse"}, 32'(bus.result_valid), 32'd0);
    endtask

    // Counts result strobes over a window with valid held low.
    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.result_valid) cnt++;
        end
    endtask

    initial begin
        int strobes;
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(bus.div_ready), 32'd1);
        check("rst.stall", 32'(bus.stall_o), 32'd0);
        check("rst.valid", 32'(bus.result_valid), 32'd0);
        check("rst.result", bus.result_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.ready", 32'(bus.div_ready), 32'd1);

        // Directed cases.
        run_op("div_100_7",  OP_DIV,  32'd100,        32'd7);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9,  32'd2);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9,  32'd2);
        run_op("remu_m7_2",  OP_REMU, 32'hFFFF_FFF9,  32'd2);
        run_op("divu_5_0",   OP_DIVU, 32'd5,          32'd0);
        run_op("rem_5_0",    OP_REM,  32'd5,          32'd0);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000,  32'hFFFF_FFFF);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_7_m2",   OP_DIV,  32'd7,          32'hFFFF_FFFE);
        run_op("rem_7_m2",   OP_REM,  32'd7,          32'hFFFF_FFFE);

        // Flush during CALC at t0+10.
        @(negedge clk);
        bus.div_valid  = 1'b1;
        bus.div_opcode = OP_DIV;
        bus.operand1   = 32'd1000;
        bus.operand2   = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush.ready", 32'(bus.div_ready), 32'd1);
        check("flush.valid", 32'(bus.result_valid), 32'd0);
        bus.flush     = 1'b0;
        bus.div_valid = 1'b0;
        count_strobes(MAX_WAIT, strobes);
        check("flush.no_result", 32'(strobes), 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3);

        // flush together with valid in IDLE: no accept.
        @(negedge clk);
        bus.div_valid  = 1'b1;
        bus.flush      = 1'b1;
        bus.div_opcode = OP_DIV;
        bus.operand1   = 32'd100;
        bus.operand2   = 32'd7;
        #1;
        check("idle_flush.stall", 32'(bus.stall_o), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_flush.ready", 32'(bus.div_ready), 32'd1);
        bus.div_valid = 1'b0;
        bus.flush     = 1'b0;

        // Reset mid-operation.
        @(negedge clk);
        bus.div_valid  = 1'b1;
        bus.div_opcode = OP_REM;
        bus.operand1   = 32'd12345;
        bus.operand2   = 32'd17;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.div_valid = 1'b0;
        #1;
        check("midrst.ready", 32'(bus.div_ready), 32'd1);
        check("midrst.stall", 32'(bus.stall_o), 32'd0);
        check("midrst.valid", 32'(bus.result_valid), 32'd0);
        check("midrst.result", bus.result_o, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_strobes(MAX_WAIT, strobes);
        check("midrst.no_result", 32'(strobes), 32'd0);
        check("midrst.result_hold", bus.result_o, 32'h0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 1200; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op("rand", op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
